// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and default constants for the TDC interval stage
package tdc_pkg;

  // Defaults shared with the gating stage and its bench
  localparam int TDC_CNT_W   = 16;
  localparam int TDC_TIMEOUT = 1000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } meas_state_t;

  typedef struct packed {
    logic                 timeout;
    logic [TDC_CNT_W-1:0] data;
  } meas_rec_t;

endpackage

// File: rtl/tdc_meas_fifo.sv
// rtl/tdc_meas_fifo.sv - first-word-fall-through FIFO of measurement records
module tdc_meas_fifo
  import tdc_pkg::*;
#(
  parameter type rec_t = meas_rec_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rec_t push_rec,
  input  logic pop,
  output rec_t head_rec,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  rec_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB separates full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when nothing is stored so stale words never leak out
  assign head_rec = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; a push into a full FIFO is only accepted alongside a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array needs no reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_rec;
  end

endmodule

// File: rtl/tdc_interval_meas.sv
// rtl/tdc_interval_meas.sv - coarse start-to-stop interval counter with result FIFO
module tdc_interval_meas
  import tdc_pkg::*;
#(
  parameter int CNT_W   = TDC_CNT_W,
  parameter int TIMEOUT = TDC_TIMEOUT,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             TDC_start,
  input  logic             TDC_stop,
  output logic [CNT_W-1:0] meas_data,
  output logic             meas_timeout,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  typedef struct packed {
    logic             timeout;
    logic [CNT_W-1:0] data;
  } rec_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

  // [0] first sync stage, [1] synchronized level, [2] previous level
  logic [2:0]       start_sh;
  logic [2:0]       stop_sh;
  logic             start_rise;
  logic             stop_rise;

  meas_state_t      state;
  meas_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic             push;
  rec_t             push_rec;
  rec_t             head_rec;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_pop;
  logic             drop;

  // Both inputs share the same synchronizer depth so their relative skew stays within one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_sh <= '0;
      stop_sh  <= '0;
    end else begin
      start_sh <= {start_sh[1:0], TDC_start};
      stop_sh  <= {stop_sh[1:0], TDC_stop};
    end
  end

  assign start_rise = start_sh[1] && !start_sh[2];
  assign stop_rise  = stop_sh[1] && !stop_sh[2];

  // State and interval counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: counter starts at 1 so it equals the elapsed cycles when stop is seen
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start_rise && !stop_rise) begin
          state_nxt = RUN;
          cnt_nxt   = CNT_W'(1);
        end
      end
      RUN: begin
        if (stop_rise || (cnt == TIMEOUT_VAL)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: a stop on the timeout cycle still wins as a normal result
  always_comb begin
    busy     = (state == RUN);
    push     = 1'b0;
    push_rec = '0;
    case (state)
      IDLE: begin
        if (start_rise && stop_rise) push = 1'b1;
      end
      RUN: begin
        if (stop_rise) begin
          push          = 1'b1;
          push_rec.data = cnt;
        end else if (cnt == TIMEOUT_VAL) begin
          push             = 1'b1;
          push_rec.timeout = 1'b1;
          push_rec.data    = TIMEOUT_VAL;
        end
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  assign fifo_pop = meas_valid && meas_ready;
  assign drop     = push && fifo_full && !fifo_pop;

  tdc_meas_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .push     (push),
    .push_rec (push_rec),
    .pop      (fifo_pop),
    .head_rec (head_rec),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Lost-result counter sticks at its maximum instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign meas_valid   = !fifo_empty;
  assign meas_data    = head_rec.data;
  assign meas_timeout = head_rec.timeout;

endmodule

// File: tb/tb_tdc_interval_meas.sv
// tb/tb_tdc_interval_meas.sv - randomized bench with behavioural interval model
`timescale 1ns/1ps
module tb_tdc_interval_meas;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             TDC_start = 1'b0;
  logic             TDC_stop = 1'b0;
  logic             meas_ready = 1'b1;
  logic [CNT_W-1:0] meas_data;
  logic             meas_timeout;
  logic             meas_valid;
  logic             busy;
  logic [7:0]       drop_cnt;

  tdc_interval_meas #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .TDC_start    (TDC_start),
    .TDC_stop     (TDC_stop),
    .meas_data    (meas_data),
    .meas_timeout (meas_timeout),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit to;
    int data;
  } rec_s;

  int   checks = 0;
  int   failures = 0;

  rec_s mq[$];
  rec_s got[$];
  int   st_eff[$];
  int   sp_eff[$];
  int   gaps[$];
  int   cyc = 0;
  bit   st_seen = 0;
  bit   sp_seen = 0;
  bit   m_meas = 0;
  int   m_start = 0;
  int   m_drops = 0;

  // Model: an input edge sampled at clock edge k acts at edge k+2; interval is the edge distance
  always @(posedge clk or negedge reset_n) begin : mdl
    bit   st;
    bit   sp;
    bit   pop;
    bit   have;
    rec_s r;
    if (!reset_n) begin
      mq.delete();
      st_eff.delete();
      sp_eff.delete();
      st_seen = 0;
      sp_seen = 0;
      m_meas  = 0;
      m_drops = 0;
    end else begin
      cyc++;
      st = (st_eff.size() > 0) && (st_eff[0] == cyc);
      if (st) void'(st_eff.pop_front());
      sp = (sp_eff.size() > 0) && (sp_eff[0] == cyc);
      if (sp) void'(sp_eff.pop_front());
      pop  = (mq.size() > 0) && meas_ready;
      have = 0;
      r.to = 0;
      r.data = 0;
      if (!m_meas) begin
        if (st && sp) begin
          have = 1;
        end else if (st) begin
          m_meas  = 1;
          m_start = cyc;
        end
      end else begin
        if (sp) begin
          have   = 1;
          r.data = cyc - m_start;
          m_meas = 0;
        end else if (cyc - m_start == TIMEOUT) begin
          have   = 1;
          r.to   = 1;
          r.data = TIMEOUT;
          m_meas = 0;
        end
      end
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(r);
        else if (m_drops < 255) m_drops++;
      end
      if (TDC_start && !st_seen) st_eff.push_back(cyc + 2);
      if (TDC_stop && !sp_seen) sp_eff.push_back(cyc + 2);
      st_seen = TDC_start;
      sp_seen = TDC_stop;
    end
  end

  // Every-cycle comparison of all outputs against the model; logs accepted DUT entries
  always @(negedge clk) begin : cmp
    logic             ev;
    logic             et;
    logic [CNT_W-1:0] ed;
    rec_s             g;
    ev = (mq.size() > 0);
    et = ev ? mq[0].to : 1'b0;
    ed = ev ? CNT_W'(mq[0].data) : '0;
    checks++;
    if (meas_valid !== ev || meas_data !== ed || meas_timeout !== et ||
        busy !== m_meas || drop_cnt !== 8'(m_drops)) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t got v=%0b d=%0d to=%0b busy=%0b drop=%0d want v=%0b d=%0d to=%0b busy=%0b drop=%0d",
               $time, meas_valid, meas_data, meas_timeout, busy, drop_cnt,
               ev, ed, et, m_meas, m_drops);
    end
    if (meas_valid && meas_ready) begin
      g.to   = meas_timeout;
      g.data = int'(meas_data);
      got.push_back(g);
    end
  end

  task automatic check(input string name, input int actual, input int want);
    checks++;
    if (actual !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, actual, want);
    end
  endtask

  // Keep input edges away from the sampling clock edge
  task automatic off_edge();
    if (($time % 20) == 10) #1;
  endtask

  task automatic pair(input int gap);
    TDC_start = 1'b1;
    fork
      begin
        #40;
        TDC_start = 1'b0;
      end
      begin
        #(gap);
        off_edge();
        TDC_stop = 1'b1;
        #40;
        TDC_stop = 1'b0;
      end
    join
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int gap;
    int expd;
    int diff;

    #15;
    check("rst_valid", int'(meas_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_data", int'(meas_data), 0);
    check("rst_timeout", int'(meas_timeout), 0);
    check("rst_drop", int'(drop_cnt), 0);
    #30;
    reset_n = 1'b1;
    cycles(5);

    // Single 400 ns interval
    #3;
    pair(400);
    cycles(10);
    check("t1_count", got.size(), 1);
    if (got.size() >= 1) begin
      check("t1_data", got[0].data, 20);
      check("t1_timeout", int'(got[0].to), 0);
    end
    check("t1_busy", int'(busy), 0);

    // Start only: timeout record, late stop ignored
    #3;
    TDC_start = 1'b1;
    #40;
    TDC_start = 1'b0;
    cycles(TIMEOUT + 10);
    check("t2_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("t2_data", got[1].data, TIMEOUT);
      check("t2_timeout", int'(got[1].to), 1);
    end
    #3;
    TDC_stop = 1'b1;
    #40;
    TDC_stop = 1'b0;
    cycles(10);
    check("t2_late_stop", got.size(), 2);
    check("t2_drop", int'(drop_cnt), 0);

    // Simultaneous start/stop, then lone stop
    #3;
    TDC_start = 1'b1;
    TDC_stop  = 1'b1;
    #40;
    TDC_start = 1'b0;
    TDC_stop  = 1'b0;
    cycles(10);
    check("t3_count", got.size(), 3);
    if (got.size() >= 3) begin
      check("t3_data", got[2].data, 0);
      check("t3_timeout", int'(got[2].to), 0);
    end
    #3;
    TDC_stop = 1'b1;
    #40;
    TDC_stop = 1'b0;
    cycles(10);
    check("t3_lone_stop", got.size(), 3);

    // Back-pressure: six results into a four-deep FIFO
    @(posedge clk);
    #1;
    meas_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      pair(400);
      #200;
    end
    cycles(5);
    check("t4_drop", int'(drop_cnt), 2);
    check("t4_valid", int'(meas_valid), 1);
    @(posedge clk);
    #1;
    meas_ready = 1'b1;
    cycles(4);
    check("t4_last_held", int'(meas_valid), 1);
    cycles(1);
    check("t4_drained", int'(meas_valid), 0);
    check("t4_count", got.size(), 7);
    for (int i = 3; i < 7 && i < got.size(); i++) begin
      check("t4_data", got[i].data, 20);
    end

    // Reset in the middle of a measurement
    @(negedge clk);
    #3;
    TDC_start = 1'b1;
    #40;
    TDC_start = 1'b0;
    cycles(10);
    check("t5_busy_before", int'(busy), 1);
    #5;
    reset_n = 1'b0;
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_valid", int'(meas_valid), 0);
    check("t5_drop", int'(drop_cnt), 0);
    #30;
    reset_n = 1'b1;
    cycles(5);
    #3;
    TDC_stop = 1'b1;
    #40;
    TDC_stop = 1'b0;
    cycles(10);
    check("t5_no_entry", got.size(), 7);

    // Randomized intervals
    for (int i = 0; i < 100; i++) begin
      gap = int'($urandom_range(484, 395));
      gaps.push_back(gap);
      @(negedge clk);
      #3;
      pair(gap);
      cycles(int'($urandom_range(12, 4)));
    end
    cycles(10);
    check("t6_count", got.size(), 107);
    for (int i = 0; i < 100 && (7 + i) < got.size(); i++) begin
      expd = (gaps[i] + 10) / 20;
      diff = got[7 + i].data - expd;
      if (diff < 0) diff = -diff;
      check("t6_within_1", int'(diff <= 1), 1);
      check("t6_no_timeout", int'(got[7 + i].to), 0);
    end
    check("t6_drop", int'(drop_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
